// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and the axi_mem_slave RAM responder.
// Every channel follows the usual AXI rule: a transfer happens on the rising
// clock edge where valid and ready are both high. Once the sender raises
// valid, it keeps valid and its payload stable until that edge.
interface axi_mem_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);
  // write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  // write data channel
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  // read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 word-addressed RAM responder. Serves one INCR burst at a time, with
// 4-byte beats. Reads and writes are serialized by a four-state FSM. Bursts
// wrap modulo the RAM depth. The write response reports SLVERR when the
// master's wlast does not line up with the beat count.
// dbg_state exposes the FSM: 0 IDLE, 1 RBURST, 2 WDATA, 3 WRESP.
module axi_mem_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 12
) (
  input  logic                clk,
  input  logic                rst,
  axi_mem_slave_if.slave      axi,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RBURST = 2'd1,
    S_WDATA  = 2'd2,
    S_WRESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [MEM_AW-1:0]     base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_fire;
  logic                  ar_fire;
  logic                  last_beat;
  logic [MEM_AW-1:0]     beat_idx;
  logic                  rd_en;
  logic [MEM_AW-1:0]     rd_idx;
  logic                  mem_we;

  // Size fields and address bits outside the RAM word index are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.awsize, axi.arsize,
                              axi.awaddr[ADDR_WIDTH-1:MEM_AW+2], axi.awaddr[1:0],
                              axi.araddr[ADDR_WIDTH-1:MEM_AW+2], axi.araddr[1:0]};

  // Current beat's RAM word. The index is truncated to MEM_AW bits, so the burst wraps.
  assign beat_idx  = base_q + MEM_AW'(cnt_q);
  assign last_beat = (cnt_q == len_q);

  // Write wins an AW/AR tie in IDLE. No address is accepted while reset is held.
  assign axi.awready = (state_q == S_IDLE) && !rst;
  assign axi.arready = (state_q == S_IDLE) && !rst && !axi.awvalid;
  assign axi.wready  = (state_q == S_WDATA);
  assign axi.bvalid  = (state_q == S_WRESP);
  assign axi.bresp   = ((state_q == S_WRESP) && err_q) ? 2'b10 : 2'b00;
  assign axi.bid     = id_q;
  assign axi.rvalid  = (state_q == S_RBURST);
  assign axi.rlast   = (state_q == S_RBURST) && last_beat;
  assign axi.rid     = id_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;
  assign dbg_state   = state_q;

  assign aw_fire = axi.awvalid && axi.awready;
  assign ar_fire = axi.arvalid && axi.arready;

  // Next-state, burst bookkeeping and RAM port control.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_idx  = beat_idx;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_fire) begin
          id_d    = axi.awid;
          base_d  = axi.awaddr[MEM_AW+1:2];
          len_d   = axi.awlen;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end else if (ar_fire) begin
          id_d    = axi.arid;
          base_d  = axi.araddr[MEM_AW+1:2];
          len_d   = axi.arlen;
          cnt_d   = 8'd0;
          rd_en   = 1'b1;
          rd_idx  = axi.araddr[MEM_AW+1:2];
          state_d = S_RBURST;
        end
      end
      S_RBURST: begin
        // rvalid is high for the whole state, so rready alone means a beat went out.
        if (axi.rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            rd_en  = 1'b1;
            rd_idx = beat_idx + MEM_AW'(1);
          end
        end
      end
      S_WDATA: begin
        if (axi.wvalid) begin
          mem_we = !rst;
          if (axi.wlast != last_beat) err_d = 1'b1;
          // The burst ends on the beat count, whatever the master says on wlast.
          if (last_beat) state_d = S_WRESP;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_WRESP: begin
        if (axi.bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers. Reset drops any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled RAM write. The write commits on the W beat, before B is sent.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (axi.wstrb[b]) mem[beat_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  // Registered read port. It loads the next beat only when the current one is accepted.
  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;

  localparam int DEPTH = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) axi ();
  logic [1:0] dbg_state;

  axi_mem_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(axi),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] last_rdata;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic int widx(input logic [31:0] a, input int i);
    return (int'(a >> 2) + i) % DEPTH;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timed_out(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
  endtask

  // ---------------- driver tasks (called and returning at posedge+1) ----------------
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int wlast_beat, input bit rnd_bready);
    int n;
    bit fire;
    logic [1:0] exp_resp;
    exp_resp = (wlast_beat == len) ? 2'b00 : 2'b10;
    axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len); axi.awsize = 3'd2; axi.awvalid = 1'b1;
    n = 0; fire = 1'b0;
    while (!fire && n < 100) begin
      @(negedge clk);
      fire = axi.awready;
      if (axi.arvalid) check("ar_blocked_aw", 32'(axi.arready), 32'd0);
      @(posedge clk); #1; n++;
    end
    axi.awvalid = 1'b0;
    if (!fire) begin timed_out("aw_timeout"); return; end
    for (int i = 0; i <= len; i++) begin
      axi.wvalid = 1'b1; axi.wdata = wbuf[i]; axi.wstrb = sbuf[i]; axi.wlast = (i == wlast_beat);
      n = 0; fire = 1'b0;
      while (!fire && n < 100) begin
        @(negedge clk);
        fire = axi.wready;
        if (axi.arvalid) check("ar_blocked_w", 32'(axi.arready), 32'd0);
        @(posedge clk); #1; n++;
      end
      if (!fire) begin
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        timed_out("w_timeout");
        return;
      end
      for (int b = 0; b < 4; b++)
        if (sbuf[i][b]) model[widx(addr, i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    n = 0; fire = 1'b0;
    while (!fire && n < 100) begin
      axi.bready = rnd_bready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (n == 0) begin
        check("wready_drop", 32'(axi.wready), 32'd0);
        check("bvalid_rise", 32'(axi.bvalid), 32'd1);
      end
      fire = axi.bvalid && axi.bready;
      if (axi.arvalid) check("ar_blocked_b", 32'(axi.arready), 32'd0);
      if (fire) begin
        check("bresp", 32'(axi.bresp), 32'(exp_resp));
        check("bid", 32'(axi.bid), 32'(id));
      end
      @(posedge clk); #1; n++;
    end
    axi.bready = 1'b0;
    if (!fire) timed_out("b_timeout");
    else if (!axi.arvalid) begin
      @(negedge clk);
      check("bvalid_drop", 32'(axi.bvalid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // mode: 0 rready always high, 1 random rready, 2 rready pattern 1,0,0,1
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int mode, input int abort_beat);
    int n, beat;
    bit fire, held;
    logic [31:0] hold_d, e;
    logic hold_l;
    axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len); axi.arsize = 3'd2; axi.arvalid = 1'b1;
    n = 0; fire = 1'b0;
    while (!fire && n < 100) begin
      @(negedge clk);
      fire = axi.arready;
      @(posedge clk); #1; n++;
    end
    axi.arvalid = 1'b0;
    if (!fire) begin timed_out("ar_timeout"); return; end
    for (int i = 0; i <= len; i++) exp_q.push_back(model[widx(addr, i)]);
    beat = 0; n = 0; held = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beat <= len && n < 3000) begin
      if (beat == abort_beat) begin
        axi.rready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_rvalid", 32'(axi.rvalid), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_awready", 32'(axi.awready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      case (mode)
        0:       axi.rready = 1'b1;
        1:       axi.rready = 1'($urandom_range(0, 1));
        default: axi.rready = ((n % 4) == 0) || ((n % 4) == 3);
      endcase
      @(negedge clk);
      if (n == 0) check("rvalid_latency", 32'(axi.rvalid), 32'd1);
      if (held) begin
        check("r_hold_data", axi.rdata, hold_d);
        check("r_hold_last", 32'(axi.rlast), 32'(hold_l));
      end
      held = 1'b0;
      if (axi.rvalid && axi.rready) begin
        e = exp_q.pop_front();
        check("rdata", axi.rdata, e);
        check("rlast", 32'(axi.rlast), 32'(beat == len));
        check("rid", 32'(axi.rid), 32'(id));
        last_rdata = axi.rdata;
        beat++;
      end else if (axi.rvalid) begin
        held = 1'b1; hold_d = axi.rdata; hold_l = axi.rlast;
      end
      @(posedge clk); #1; n++;
    end
    axi.rready = 1'b0;
    if (beat <= len) begin
      timed_out("r_timeout");
      exp_q.delete();
    end else begin
      @(negedge clk);
      check("rvalid_drop", 32'(axi.rvalid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int len, wl;
    logic [31:0] addr;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    last_rdata = '0;

    vecs[0] = '{addr: 32'h10,    init: 32'h0,        data: 32'hDEADBEEF, strb: 4'hF, raddr: 32'h10,       exp: 32'hDEADBEEF};
    vecs[1] = '{addr: 32'h20,    init: 32'h11223344, data: 32'hAABBCCDD, strb: 4'h5, raddr: 32'h20,       exp: 32'h11BB33DD};
    vecs[2] = '{addr: 32'h24,    init: 32'h11223344, data: 32'hAABBCCDD, strb: 4'h0, raddr: 32'h24,       exp: 32'h11223344};
    vecs[3] = '{addr: 32'h28,    init: 32'h0,        data: 32'hFFFFFFFF, strb: 4'h8, raddr: 32'h28,       exp: 32'hFF000000};
    vecs[4] = '{addr: 32'h4002F, init: 32'h01020304, data: 32'hCAFEF00D, strb: 4'h2, raddr: 32'h2C,       exp: 32'h0102F004};
    vecs[5] = '{addr: 32'h3FFC,  init: 32'h0,        data: 32'h12345678, strb: 4'hF, raddr: 32'hFFFFFFFC, exp: 32'h12345678};

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_wready",  32'(axi.wready),  32'd0);
    check("rst_bvalid",  32'(axi.bvalid),  32'd0);
    check("rst_rvalid",  32'(axi.rvalid),  32'd0);
    check("rst_rlast",   32'(axi.rlast),   32'd0);
    check("rst_bresp",   32'(axi.bresp),   32'd0);
    check("rst_rresp",   32'(axi.rresp),   32'd0);
    check("rst_bid",     32'(axi.bid),     32'd0);
    check("rst_rid",     32'(axi.rid),     32'd0);
    check("rst_rdata",   axi.rdata,        32'd0);
    check("rst_state",   32'(dbg_state),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", 32'(axi.awready), 32'd1);
    check("idle_arready", 32'(axi.arready), 32'd1);
    @(posedge clk); #1;

    // single-beat write/strobe/readback vectors
    for (int v = 0; v < 6; v++) begin
      wbuf[0] = vecs[v].init; sbuf[0] = 4'hF;
      axi_write(4'(v + 1), vecs[v].addr, 0, 0, 1'b0);
      wbuf[0] = vecs[v].data; sbuf[0] = vecs[v].strb;
      axi_write(4'(v + 9), vecs[v].addr, 0, 0, 1'b0);
      axi_read(4'(v + 3), vecs[v].raddr, 0, 0, -1);
      check("vec_readback", last_rdata, vecs[v].exp);
    end

    // fill the whole RAM with random data using maximum-length bursts
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      axi_write(4'(k), 32'(k * 1024), 255, 255, 1'(k % 2));
    end

    // 16-beat write of 0..15 at 0x100, read back in order
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
    axi_write(4'h5, 32'h100, 15, 15, 1'b0);
    axi_read(4'h6, 32'h100, 15, 0, -1);
    check("burst16_last", last_rdata, 32'd15);

    // R backpressure 1,0,0,1 during a 4-beat read
    axi_read(4'h7, 32'h100, 3, 2, -1);
    check("stall_last", last_rdata, 32'd3);

    // burst wrapping past the last RAM word
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(4'h8, 32'h3FF8, 3, 3, 1'b0);
    axi_read(4'h9, 32'hFFFF3FF8, 3, 1, -1);

    // AW and AR raised together, with wlast early on beat 2 of 4
    axi.arid = 4'hA; axi.araddr = 32'h200; axi.arlen = 8'd3; axi.arsize = 3'd2; axi.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA000_0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(4'hB, 32'h200, 3, 2, 1'b0);
    axi_read(4'hA, 32'h200, 3, 0, -1);
    check("early_wlast_beat3", last_rdata, 32'hA000_0003);

    // reset while beat 7 of a 16-beat read is on the bus, then a clean read
    axi_read(4'hC, 32'h100, 15, 0, 7);
    axi_read(4'hD, 32'h100, 15, 1, -1);

    // random traffic against the model
    for (int t = 0; t < 30; t++) begin
      addr = $urandom;
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wbuf[i] = $urandom;
          sbuf[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        end
        wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len + 1)) : len;
        axi_write(4'($urandom_range(0, 15)), addr, len, wl, 1'b1);
      end else begin
        axi_read(4'($urandom_range(0, 15)), addr, len, 1, -1);
      end
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
